// File: rtl/snake_core_param.sv
// Parametrised snake datapath: body storage, movement, growth, wall/self collision
// and the IDLE/RUN/PAUSE/DONE game FSM, with per-pixel head/body queries.
module snake_core_param #(
    parameter int unsigned GRID_W      = 16,
    parameter int unsigned GRID_H      = 12,
    parameter int unsigned MAX_LENGTH  = 140,
    parameter int unsigned INIT_LENGTH = 3,
    parameter int unsigned WRAP        = 0,
    localparam int unsigned XW = $clog2(GRID_W),
    localparam int unsigned YW = $clog2(GRID_H),
    localparam int unsigned LW = $clog2(MAX_LENGTH + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          step,
    input  logic          start,
    input  logic          pause,
    input  logic          dir_valid,
    input  logic [1:0]    dir,
    input  logic [XW-1:0] apple_x,
    input  logic [YW-1:0] apple_y,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic [1:0]    state,
    output logic          ate,
    output logic          game_over,
    output logic          win,
    output logic          q_head,
    output logic          q_body
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_RIGHT = 2'b01;
    localparam logic [1:0] D_DOWN  = 2'b10;
    localparam logic [1:0] D_LEFT  = 2'b11;

    localparam logic [XW-1:0] X_MAX  = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(GRID_H - 1);
    localparam logic [YW-1:0] Y_MID  = YW'(GRID_H / 2);
    localparam logic [LW-1:0] L_INIT = LW'(INIT_LENGTH);
    localparam logic [LW-1:0] L_MAX  = LW'(MAX_LENGTH);

    logic [1:0]    state_q,   state_d;
    logic [1:0]    heading_q, heading_d;
    logic [1:0]    pending_q, pending_d;
    logic [LW-1:0] length_q,  length_d;
    logic          ate_q,     ate_d;
    logic          over_q,    over_d;
    logic          win_q,     win_d;
    logic [XW-1:0] seg_x_q [MAX_LENGTH];
    logic [XW-1:0] seg_x_d [MAX_LENGTH];
    logic [YW-1:0] seg_y_q [MAX_LENGTH];
    logic [YW-1:0] seg_y_d [MAX_LENGTH];

    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;
    logic [LW-1:0] self_lim;
    logic          border_hit;
    logic          self_hit;
    logic          eat;

    // Starting body: horizontal line ending at the grid centre, head rightmost
    function automatic logic [XW-1:0] init_x(input int unsigned i);
        return (i < INIT_LENGTH) ? XW'(GRID_W / 2 - i) : '0;
    endfunction

    // Candidate head cell for the pending direction, always wrapped explicitly
    always_comb begin
        nxt_x = seg_x_q[0];
        nxt_y = seg_y_q[0];
        case (pending_q)
            D_UP:    nxt_y = (seg_y_q[0] == '0)    ? Y_MAX : seg_y_q[0] - YW'(1);
            D_DOWN:  nxt_y = (seg_y_q[0] == Y_MAX) ? '0    : seg_y_q[0] + YW'(1);
            D_LEFT:  nxt_x = (seg_x_q[0] == '0)    ? X_MAX : seg_x_q[0] - XW'(1);
            default: nxt_x = (seg_x_q[0] == X_MAX) ? '0    : seg_x_q[0] + XW'(1);
        endcase
    end

    // Collision and eat detection; the tail cell is free unless the snake grows
    always_comb begin
        border_hit = 1'b0;
        if (WRAP == 0) begin
            border_hit = (nxt_x == '0) || (nxt_x == X_MAX) ||
                         (nxt_y == '0) || (nxt_y == Y_MAX);
        end
        eat      = (nxt_x == apple_x) && (nxt_y == apple_y);
        self_lim = eat ? length_q : length_q - LW'(1);
        self_hit = 1'b0;
        for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
            if ((LW'(i) < self_lim) && (seg_x_q[i] == nxt_x) && (seg_y_q[i] == nxt_y)) begin
                self_hit = 1'b1;
            end
        end
    end

    // Pixel queries against the live segment range only
    always_comb begin
        q_head = (query_x == seg_x_q[0]) && (query_y == seg_y_q[0]);
        q_body = 1'b0;
        for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
            if ((LW'(i) < length_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
                q_body = 1'b1;
            end
        end
    end

    // Next-state logic: start > pause > step, then direction sampling
    always_comb begin
        state_d   = state_q;
        heading_d = heading_q;
        pending_d = pending_q;
        length_d  = length_q;
        ate_d     = 1'b0;
        over_d    = over_q;
        win_d     = win_q;
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end

        if (start) begin
            if (state_q == S_IDLE) begin
                state_d = S_RUN;
            end else if (state_q == S_DONE) begin
                state_d   = S_RUN;
                heading_d = D_RIGHT;
                pending_d = D_RIGHT;
                length_d  = L_INIT;
                over_d    = 1'b0;
                win_d     = 1'b0;
                for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
                    seg_x_d[i] = init_x(i);
                    seg_y_d[i] = Y_MID;
                end
            end
        end else if (pause) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end else if (state_q == S_PAUSE) begin
                state_d = S_RUN;
            end
        end else if (step && (state_q == S_RUN)) begin
            heading_d = pending_q;
            if (border_hit || self_hit) begin
                state_d = S_DONE;
                over_d  = 1'b1;
            end else begin
                for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = nxt_x;
                seg_y_d[0] = nxt_y;
                length_d   = length_q + LW'(eat);
                ate_d      = eat;
                if (length_d == L_MAX) begin
                    state_d = S_DONE;
                    win_d   = 1'b1;
                end
            end
        end

        // Reversal check uses the heading in force after this edge's move
        if (dir_valid && (state_q != S_DONE) && (dir != (heading_d ^ 2'b10))) begin
            pending_d = dir;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            heading_q <= D_RIGHT;
            pending_q <= D_RIGHT;
            length_q  <= L_INIT;
            ate_q     <= 1'b0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= Y_MID;
            end
        end else begin
            state_q   <= state_d;
            heading_q <= heading_d;
            pending_q <= pending_d;
            length_q  <= length_d;
            ate_q     <= ate_d;
            over_q    <= over_d;
            win_q     <= win_d;
            for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = length_q;
    assign state     = state_q;
    assign ate       = ate_q;
    assign game_over = over_q;
    assign win       = win_q;

endmodule

// File: tb/tb_snake_core_param.sv
// Bench for snake_core_param: walled, wrapping and short-max instances share stimulus,
// each tracked by a list-based game model.
module tb_snake_core_param;

    localparam int GW = 16;
    localparam int GH = 12;
    localparam int IL = 3;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst, step, start, pause, dir_valid;
    logic [1:0] dir;
    logic [3:0] apple_x, apple_y, query_x, query_y;

    logic [3:0] hx [3];
    logic [3:0] hy [3];
    logic [1:0] st [3];
    logic       at [3], go [3], wn [3], qh [3], qb [3];
    logic [7:0] len0, len1;
    logic [2:0] len2;

    snake_core_param #(.WRAP(0)) u_wall (
        .clk(clk), .nrst(nrst), .step(step), .start(start), .pause(pause),
        .dir_valid(dir_valid), .dir(dir), .apple_x(apple_x), .apple_y(apple_y),
        .query_x(query_x), .query_y(query_y), .head_x(hx[0]), .head_y(hy[0]),
        .length(len0), .state(st[0]), .ate(at[0]), .game_over(go[0]), .win(wn[0]),
        .q_head(qh[0]), .q_body(qb[0]));

    snake_core_param #(.WRAP(1)) u_wrap (
        .clk(clk), .nrst(nrst), .step(step), .start(start), .pause(pause),
        .dir_valid(dir_valid), .dir(dir), .apple_x(apple_x), .apple_y(apple_y),
        .query_x(query_x), .query_y(query_y), .head_x(hx[1]), .head_y(hy[1]),
        .length(len1), .state(st[1]), .ate(at[1]), .game_over(go[1]), .win(wn[1]),
        .q_head(qh[1]), .q_body(qb[1]));

    snake_core_param #(.MAX_LENGTH(4)) u_short (
        .clk(clk), .nrst(nrst), .step(step), .start(start), .pause(pause),
        .dir_valid(dir_valid), .dir(dir), .apple_x(apple_x), .apple_y(apple_y),
        .query_x(query_x), .query_y(query_y), .head_x(hx[2]), .head_y(hy[2]),
        .length(len2), .state(st[2]), .ate(at[2]), .game_over(go[2]), .win(wn[2]),
        .q_head(qh[2]), .q_body(qb[2]));

    int maxl [3] = '{140, 140, 4};
    int wrp  [3] = '{0, 1, 0};

    // Model: body as a coordinate list, element 0 is the head
    int m_x [3][256];
    int m_y [3][256];
    int m_len [3], m_st [3], m_hd [3], m_pd [3], m_ate [3], m_over [3], m_win [3];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic int dut_len(input int k);
        if (k == 0) return int'(len0);
        if (k == 1) return int'(len1);
        return int'(len2);
    endfunction

    function automatic void model_init(input int k);
        m_st[k] = ST_IDLE; m_len[k] = IL; m_hd[k] = 1; m_pd[k] = 1;
        m_ate[k] = 0; m_over[k] = 0; m_win[k] = 0;
        for (int i = 0; i < IL; i++) begin
            m_x[k][i] = GW / 2 - i;
            m_y[k][i] = GH / 2;
        end
    endfunction

    function automatic void model_next(input int k, output int nx, output int ny);
        int dx, dy;
        dx = 0; dy = 0;
        case (m_pd[k])
            0: dy = -1;
            1: dx = 1;
            2: dy = 1;
            default: dx = -1;
        endcase
        nx = (m_x[k][0] + dx + GW) % GW;
        ny = (m_y[k][0] + dy + GH) % GH;
    endfunction

    function automatic void model_edge(input int k);
        int pre, nx, ny, lim, hit, eat_i;
        m_ate[k] = 0;
        if (!nrst) begin
            model_init(k);
            return;
        end
        pre = m_st[k];
        if (start) begin
            if (pre == ST_IDLE) m_st[k] = ST_RUN;
            else if (pre == ST_DONE) begin
                model_init(k);
                m_st[k] = ST_RUN;
            end
        end else if (pause) begin
            if (pre == ST_RUN) m_st[k] = ST_PAUSE;
            else if (pre == ST_PAUSE) m_st[k] = ST_RUN;
        end else if (step && pre == ST_RUN) begin
            m_hd[k] = m_pd[k];
            model_next(k, nx, ny);
            eat_i = (nx == int'(apple_x) && ny == int'(apple_y)) ? 1 : 0;
            hit = 0;
            if (wrp[k] == 0 && (nx == 0 || nx == GW-1 || ny == 0 || ny == GH-1)) hit = 1;
            lim = eat_i ? m_len[k] : m_len[k] - 1;
            for (int i = 1; i < lim; i++)
                if (m_x[k][i] == nx && m_y[k][i] == ny) hit = 1;
            if (hit) begin
                m_st[k] = ST_DONE;
                m_over[k] = 1;
            end else begin
                for (int i = m_len[k]; i >= 1; i--) begin
                    m_x[k][i] = m_x[k][i-1];
                    m_y[k][i] = m_y[k][i-1];
                end
                m_x[k][0] = nx; m_y[k][0] = ny;
                m_len[k] += eat_i;
                m_ate[k] = eat_i;
                if (m_len[k] == maxl[k]) begin
                    m_st[k] = ST_DONE;
                    m_win[k] = 1;
                end
            end
        end
        if (dir_valid && pre != ST_DONE && int'(dir) != (m_hd[k] ^ 2)) m_pd[k] = int'(dir);
    endfunction

    // One clock: advance models with the applied inputs, then compare registered outputs
    task automatic cycle();
        for (int k = 0; k < 3; k++) model_edge(k);
        @(posedge clk);
        #1;
        step = 0; start = 0; pause = 0; dir_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.head_x", k), int'(hx[k]), m_x[k][0]);
            chk($sformatf("u%0d.head_y", k), int'(hy[k]), m_y[k][0]);
            chk($sformatf("u%0d.length", k), dut_len(k), m_len[k]);
            chk($sformatf("u%0d.state", k), int'(st[k]), m_st[k]);
            chk($sformatf("u%0d.ate", k), int'(at[k]), m_ate[k]);
            chk($sformatf("u%0d.game_over", k), int'(go[k]), m_over[k]);
            chk($sformatf("u%0d.win", k), int'(wn[k]), m_win[k]);
        end
    endtask

    task automatic qcheck(input int x, input int y);
        int eh, eb;
        query_x = 4'(x); query_y = 4'(y);
        #1;
        for (int k = 0; k < 3; k++) begin
            eh = (m_x[k][0] == x && m_y[k][0] == y) ? 1 : 0;
            eb = 0;
            for (int i = 1; i < m_len[k]; i++)
                if (m_x[k][i] == x && m_y[k][i] == y) eb = 1;
            chk($sformatf("u%0d.q_head(%0d,%0d)", k, x, y), int'(qh[k]), eh);
            chk($sformatf("u%0d.q_body(%0d,%0d)", k, x, y), int'(qb[k]), eb);
        end
    endtask

    task automatic do_reset();
        nrst = 0; cycle(); cycle(); nrst = 1; cycle();
    endtask
    task automatic do_step();  step = 1;  cycle(); endtask
    task automatic do_start(); start = 1; cycle(); endtask
    task automatic do_pause(); pause = 1; cycle(); endtask
    task automatic do_dir(input int d);
        dir_valid = 1; dir = 2'(d); cycle();
    endtask
    task automatic set_apple(input int x, input int y);
        apple_x = 4'(x); apple_y = 4'(y);
    endtask

    initial begin
        int nx, ny;
        nrst = 0; step = 0; start = 0; pause = 0; dir_valid = 0; dir = 2'd1;
        apple_x = 0; apple_y = 0; query_x = 0; query_y = 0;
        for (int k = 0; k < 3; k++) model_init(k);

        // Reset picture
        do_reset();
        qcheck(8, 6); qcheck(7, 6); qcheck(6, 6);
        cycle();
        qcheck(5, 6);
        chk("rst.length", int'(len0), 3);
        chk("rst.state", int'(st[0]), ST_IDLE);
        chk("rst.head_x", int'(hx[0]), 8);

        // Straight run and rejected reversal
        do_start(); do_step(); do_step(); do_step();
        chk("run.head_x", int'(hx[0]), 11);
        do_dir(3); do_step();
        chk("rev.head_x", int'(hx[0]), 12);

        // Eat, wall/wrap, short-max win, restart
        do_reset(); set_apple(9, 6); do_start(); do_step();
        chk("eat.ate", int'(at[0]), 1);
        chk("eat.length", int'(len0), 4);
        qcheck(6, 6);
        set_apple(0, 0);
        cycle();
        chk("win.state", int'(st[2]), ST_DONE);
        chk("win.flag", int'(wn[2]), 1);
        repeat (5) do_step();
        do_step();
        chk("wall.state", int'(st[0]), ST_DONE);
        chk("wall.over", int'(go[0]), 1);
        chk("wall.head_x", int'(hx[0]), 14);
        chk("wrap.head_x15", int'(hx[1]), 15);
        do_step();
        chk("wrap.head_x0", int'(hx[1]), 0);
        chk("wrap.state", int'(st[1]), ST_RUN);
        do_start();
        chk("restart.state", int'(st[2]), ST_RUN);
        chk("restart.length", int'(len2), 3);
        chk("restart.head_x", int'(hx[2]), 8);

        // Coil into own neck at length 5
        do_reset(); set_apple(9, 6); do_start(); do_step();
        set_apple(10, 6); do_step(); set_apple(0, 0);
        do_dir(0); do_step(); do_dir(3); do_step(); do_dir(2); do_step();
        chk("coil.state", int'(st[0]), ST_DONE);
        chk("coil.over", int'(go[0]), 1);

        // Chase the vacating tail at length 4
        do_reset(); set_apple(9, 6); do_start(); do_step(); set_apple(0, 0);
        do_dir(0); do_step(); do_dir(3); do_step(); do_dir(2); do_step();
        chk("tail.state", int'(st[0]), ST_RUN);
        chk("tail.head_y", int'(hy[0]), 6);

        // Pause wins over a same-cycle step; step ignored while paused
        pause = 1; step = 1; cycle();
        chk("pause.state", int'(st[0]), ST_PAUSE);
        chk("pause.head_x", int'(hx[0]), 8);
        do_step(); do_pause();
        chk("resume.state", int'(st[0]), ST_RUN);

        // Randomised play
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            nrst      = ($urandom_range(0, 299) != 0);
            step      = ($urandom_range(0, 99) < 50);
            dir_valid = ($urandom_range(0, 99) < 30);
            dir       = 2'($urandom_range(0, 3));
            pause     = ($urandom_range(0, 99) < 3);
            start     = ($urandom_range(0, 99) < 3) ||
                        ((m_st[0] == ST_DONE || m_st[0] == ST_IDLE) && $urandom_range(0, 99) < 25);
            if ($urandom_range(0, 99) < 30) begin
                model_next(0, nx, ny);
                set_apple(nx, ny);
            end else if ($urandom_range(0, 99) < 15) begin
                set_apple($urandom_range(0, GW-1), $urandom_range(0, GH-1));
            end
            cycle();
            qcheck($urandom_range(0, GW-1), $urandom_range(0, GH-1));
            qcheck(m_x[0][m_len[0]-1], m_y[0][m_len[0]-1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/snake_core_param.md
Name: snake_core_param

Overview:
- Parametrised successor to the fixed 16x12 / 140-segment snake datapath.
- Owns the following in one block: snake body storage, movement, growth, self/border collision and the game state FSM.
- Configurable in grid size, maximum length, initial length and edge mode (walled or wrap-around).
- Sits between the input synchroniser/edge detectors and the image generator. Answers per-pixel head/body queries and reports eat/over/win events to the score logic.

Parameters:
GRID_W, 16, grid width in cells (>=4)
GRID_H, 12, grid height in cells (>=4)
MAX_LENGTH, 140, maximum segments including head (>=INIT_LENGTH+1)
INIT_LENGTH, 3, length after reset/restart (>=2, <GRID_W/2)
WRAP, 0, 0 = outer ring is wall; 1 = no walls, coordinates wrap

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
step  in  1  one-cycle move tick
start  in  1  one-cycle start/restart pulse
pause  in  1  one-cycle pause toggle pulse
dir_valid  in  1  qualifies dir
dir  in  2  00 up(y-1), 01 right(x+1), 10 down(y+1), 11 left(x-1)
apple_x  in  XW=$clog2(GRID_W)  apple column
apple_y  in  YW=$clog2(GRID_H)  apple row
query_x  in  XW  pixel-query column
query_y  in  YW  pixel-query row
head_x  out  XW  current head column
head_y  out  YW  current head row
length  out  LW=$clog2(MAX_LENGTH+1)  current segment count
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
ate  out  1  one-cycle pulse when a move ate the apple
game_over  out  1  high in DONE after a collision
win  out  1  high in DONE after reaching MAX_LENGTH
q_head  out  1  combinational: query == head
q_body  out  1  combinational: query == any segment 1..length-1

Behaviour:
- Reset (nrst=0 at clk edge) and the initial state:
  - state=IDLE.
  - head=(GRID_W/2, GRID_H/2).
  - Segment i sits at (GRID_W/2-i, GRID_H/2) for i<INIT_LENGTH.
  - length=INIT_LENGTH.
  - Heading and pending direction = right.
  - ate=0, game_over=0, win=0.
  - Unused segment registers are don't-care but excluded from q_body.
- FSM:
  - IDLE: start -> RUN.
  - RUN: pause -> PAUSE; collision -> DONE with game_over=1; length reaches MAX_LENGTH -> DONE with win=1.
  - PAUSE: pause -> RUN; step is ignored.
  - DONE: start -> reinitialise to the reset state and go directly to RUN.
  - Any other input in DONE is ignored.
- Priority in one cycle: nrst > start > pause > step.
  - start with step: no move.
  - pause with step in RUN: enter PAUSE, no move.
- Direction:
  - A dir_valid sample is accepted into the pending direction in IDLE, RUN or PAUSE.
  - A sample opposite to the current heading (heading of the last executed move) is ignored.
  - With several accepted samples between steps, the last one wins.
  - On a step, pending is copied to heading.
- Move, on step in RUN, all updated at that clock edge:
  - next = head + direction delta.
  - WRAP=1: coordinates wrap modulo GRID_W/GRID_H (0-1 -> GRID_W-1; GRID_W-1+1 -> 0).
  - WRAP=0: next on row 0, row GRID_H-1, col 0 or col GRID_W-1 is a border collision.
  - eat = (next == apple).
  - Self collision: next equals a segment i with 1 <= i < length-1 when not eating, or 1 <= i < length when eating. The vacating tail is legal.
  - Collision: no shift, length unchanged, state -> DONE, game_over=1.
  - Otherwise: segments shift (seg[i] <= seg[i-1]), seg[0] <= next, length += eat.
  - ate is asserted for exactly the one cycle after the edge at which the move executed.
  - If the new length == MAX_LENGTH, state -> DONE and win=1 on the same edge.
- Outputs head_x/head_y/length are registered; latency 1 cycle from the step sample.
- q_head/q_body are purely combinational from the query and registered state. They are valid in every state, including DONE (the frozen final picture).
- Arithmetic:
  - Coordinates are unsigned XW/YW bits; wrap is explicit, not relying on power-of-two overflow.
  - length never exceeds MAX_LENGTH.

Test Plan:
- Reset, then query (8,6),(7,6),(6,6),(5,6) -> q_head=1 only at (8,6); q_body=1 at (7,6),(6,6); (5,6) both 0; length=3; state=IDLE.
- start, then 3 steps heading right -> head=(11,6), length=3; then dir=left -> ignored; next step head=(12,6).
- Apple at (9,6), start, step -> ate pulses 1 cycle, length=4, tail remains (6,6).
- WRAP=0, head driven right to x=14, step -> state=DONE, game_over=1, head unchanged at (14,6). WRAP=1 same run -> head goes 15 then 0, no collision.
- Length 5, coil the snake into its own neck via up/left/down -> DONE + game_over. Separately, move into the cell the tail is vacating -> legal, still RUN.
- Same-cycle pause+step in RUN -> PAUSE, no move. Separately, with MAX_LENGTH=4 eat once -> DONE, win=1. Then start -> RUN with length=3 and head=(8,6).
